// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown display: converter FSM states,
// scan digit indices and the common-anode 7-segment code table.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] DIG_ONES = 2'd0;
  localparam logic [1:0] DIG_TENS = 2'd1;
  localparam logic [1:0] DIG_HUND = 2'd2;
  localparam logic [1:0] DIG_NONE = 2'd3;

  // Active-low segments, bit order {g,f,e,d,c,b,a}; non-decimal values blank.
  function automatic logic [6:0] seg_of(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'b1000000;
      4'd1:    code = 7'b1111001;
      4'd2:    code = 7'b0100100;
      4'd3:    code = 7'b0110000;
      4'd4:    code = 7'b0011001;
      4'd5:    code = 7'b0010010;
      4'd6:    code = 7'b0000010;
      4'd7:    code = 7'b1111000;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0010000;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/countdown_display_if.sv
// Count input from the countdown block and display pin outputs, bundled.
// The slave side is the display; the master side feeds counts and observes pins.
interface countdown_display_if;
  logic [7:0] count_in;
  logic       count_valid;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       bcd_busy;

  modport master (
    output count_in, count_valid,
    input  an, seg, dp, bcd_busy
  );

  modport slave (
    input  count_in, count_valid,
    output an, seg, dp, bcd_busy
  );
endinterface

// File: rtl/countdown_display_bin8_to_bcd.sv
// Sequential double-dabble: 8-bit binary to three BCD digits in
// 8 SHIFT cycles followed by one DONE cycle where bcd is final.
module bin8_to_bcd
  import countdown_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  bin_in,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  bcd_state_e  state_q, state_d;
  logic [19:0] sr_q, sr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [19:0] adj;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == 3'd7) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Add-3 correction on each nibble >= 5, then shift {bcd,bin} left by one.
  always_comb begin
    adj   = sr_q;
    sr_d  = sr_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sr_q[8 + 4*i +: 4] >= 4'd5) adj[8 + 4*i +: 4] = sr_q[8 + 4*i +: 4] + 4'd3;
    end
    if (state_q == IDLE && start) begin
      sr_d  = {12'd0, bin_in};
      cnt_d = 3'd0;
    end else if (state_q == SHIFT) begin
      sr_d  = {adj[18:0], 1'b0};
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
    bcd  = sr_q[19:8];
  end

endmodule

// File: rtl/countdown_display.sv
// Shows the countdown value in decimal on a 4-digit common-anode display:
// change detect feeds the BCD converter, a refresh scanner multiplexes digits.
module countdown_display
  import countdown_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100_000,
  parameter bit          BLANK_LEAD  = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  countdown_display_if.slave  bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [7:0]       shadow_q, shadow_d;
  logic [3:0]       hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
  logic [CNT_W-1:0] refresh_q, refresh_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             conv_start, conv_busy, conv_done;
  logic [11:0]      conv_bcd;

  bin8_to_bcd u_bcd (
    .clock  (clock),
    .reset  (reset),
    .start  (conv_start),
    .bin_in (bus.count_in),
    .busy   (conv_busy),
    .done   (conv_done),
    .bcd    (conv_bcd)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      shadow_q  <= '0;
      hund_q    <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
      refresh_q <= '0;
      idx_q     <= '0;
      an_q      <= 4'b1111;
      seg_q     <= SEG_BLANK;
    end else begin
      shadow_q  <= shadow_d;
      hund_q    <= hund_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      refresh_q <= refresh_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  // Changes while converting are ignored; the compare re-runs once idle.
  always_comb begin
    conv_start = !conv_busy && (bus.count_in != shadow_q);
    shadow_d   = conv_start ? bus.count_in : shadow_q;
    hund_d     = conv_done ? conv_bcd[11:8] : hund_q;
    tens_d     = conv_done ? conv_bcd[7:4]  : tens_q;
    ones_d     = conv_done ? conv_bcd[3:0]  : ones_q;
  end

  always_comb begin
    refresh_d = refresh_q + 1'b1;
    idx_d     = idx_q;
    if (refresh_q == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_d = '0;
      idx_d     = idx_q + 2'd1;
    end
  end

  // Leading-zero blanking: tens only blanks when hundreds is blank too.
  always_comb begin
    seg_d = SEG_BLANK;
    unique case (idx_q)
      DIG_ONES: seg_d = seg_of(ones_q);
      DIG_TENS: if (!(BLANK_LEAD && hund_q == 4'd0 && tens_q == 4'd0)) seg_d = seg_of(tens_q);
      DIG_HUND: if (!(BLANK_LEAD && hund_q == 4'd0)) seg_d = seg_of(hund_q);
      DIG_NONE: seg_d = SEG_BLANK;
      default:  seg_d = SEG_BLANK;
    endcase
    an_d = bus.count_valid ? ~(4'b0001 << idx_q) : 4'b1111;
  end

  assign bus.an       = an_q;
  assign bus.seg      = seg_q;
  assign bus.dp       = 1'b1;
  assign bus.bcd_busy = conv_busy;

endmodule
